bench_race_ctrl: RTL and testbench

BENCH_RACE_CTRL -- requirements
Module: bench_race_ctrl

---
 rtl/bench_race_ctrl_if.sv | 31 +++
 rtl/bench_race_ctrl.sv | 129 ++++++++++++
 tb/tb_bench_race_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bench_race_ctrl_if.sv
// bench_race_ctrl_if: control, channel and register-read signals of the benchmark race controller.
interface bench_race_ctrl_if #(
    parameter int N_CH   = 4,
    parameter int RUNS_W = 8
);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    logic              start;
    logic              abort;
    logic              soft_clear;
    logic [RUNS_W-1:0] runs;
    logic [N_CH-1:0]   ch_start;
    logic [N_CH-1:0]   ch_done;
    logic              busy;
    logic              done;
    logic              done_latched;
    logic [N_CH-1:0]   winner_onehot;
    logic [IDX_W-1:0]  winner_idx;
    logic              timeout_any;
    logic              rd_en;
    logic [5:0]        rd_addr;
    logic [31:0]       rd_data;
    logic              rd_valid;
    modport master (
        output start, abort, soft_clear, runs, ch_done, rd_en, rd_addr,
        input  ch_start, busy, done, done_latched, winner_onehot, winner_idx, timeout_any, rd_data, rd_valid
    );
    modport slave (
        input  start, abort, soft_clear, runs, ch_done, rd_en, rd_addr,
        output ch_start, busy, done, done_latched, winner_onehot, winner_idx, timeout_any, rd_data, rd_valid
    );
endinterface

// File: rtl/bench_race_ctrl.sv
// bench_race_ctrl: launches N_CH channel engines for several runs, times each run per channel,
// accumulates saturating totals and picks the fastest channel that never timed out.
module bench_race_ctrl #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1000000,
    parameter int RUNS_W  = 8
) (
    input logic clk,
    input logic rst,
    bench_race_ctrl_if.slave bus
);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [2:0] IDLE = 3'd0, LAUNCH = 3'd1, MEASURE = 3'd2, ACCUM = 3'd3, DECIDE = 3'd4;
    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

    logic [2:0]        state;
    logic [CNT_W-1:0]  g;
    logic [CNT_W-1:0]  cnt [N_CH];
    logic [CNT_W-1:0]  total [N_CH];
    logic [CNT_W:0]    sum [N_CH];
    logic [N_CH-1:0]   fin, to_flag;
    logic [RUNS_W-1:0] runs_q, run_cnt;
    logic [RUNS_W:0]   runs_eff;
    logic              hit, all_fin, last_run, w_found;
    logic [IDX_W-1:0]  w_idx;
    logic [CNT_W-1:0]  w_min;
    logic [31:0]       rd_mux;

    assign hit = g + CNT_W'(1) == TO;
    assign all_fin = &(fin | bus.ch_done);
    assign runs_eff = runs_q == '0 ? (RUNS_W+1)'(1) : {1'b0, runs_q};
    assign last_run = {1'b0, run_cnt} + (RUNS_W+1)'(1) >= runs_eff;
    assign bus.ch_start = {N_CH{state == LAUNCH}};
    assign bus.busy = state != IDLE;

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        w_found = 1'b0;
        w_idx = '0;
        w_min = '0;
        for (int i = 0; i < N_CH; i++) begin
            sum[i] = {1'b0, total[i]} + {1'b0, cnt[i]};
            if (!to_flag[i] && (!w_found || total[i] < w_min)) begin
                w_found = 1'b1;
                w_idx = IDX_W'(i);
                w_min = total[i];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (bus.rd_addr == 6'h00) rd_mux = {29'b0, bus.timeout_any, bus.done_latched, bus.busy};
        if (bus.rd_addr == 6'h01) rd_mux = 32'(bus.winner_idx) << 8 | 32'(bus.winner_onehot);
        if (bus.rd_addr == 6'h02) rd_mux = 32'(run_cnt);
        for (int i = 0; i < N_CH; i++) begin
            if (bus.rd_addr == 6'(16 + i)) rd_mux = 32'(cnt[i]);
            if (bus.rd_addr == 6'(32 + i)) rd_mux = 32'(total[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            g <= '0;
            fin <= '0;
            to_flag <= '0;
            runs_q <= '0;
            run_cnt <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
                total[i] <= '0;
            end
            bus.done <= 1'b0;
            bus.done_latched <= 1'b0;
            bus.winner_onehot <= '0;
            bus.winner_idx <= '0;
            bus.timeout_any <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data <= '0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) bus.rd_data <= rd_mux;
            bus.done <= 1'b0;
            if (bus.soft_clear) bus.done_latched <= 1'b0;
            // Abort only redirects the FSM; all counters stay frozen for readback.
            if (bus.abort) state <= IDLE;
            else case (state)
                IDLE: if (bus.start) begin
                    state <= LAUNCH;
                    runs_q <= bus.runs;
                    run_cnt <= '0;
                    to_flag <= '0;
                    for (int i = 0; i < N_CH; i++) total[i] <= '0;
                    bus.done_latched <= 1'b0;
                end
                LAUNCH: begin
                    state <= MEASURE;
                    g <= '0;
                    fin <= '0;
                    for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
                end
                // An unfinished channel's count equals g+1, so it lands on TIMEOUT at expiry.
                MEASURE: begin
                    g <= g + CNT_W'(1);
                    for (int i = 0; i < N_CH; i++) if (!fin[i]) cnt[i] <= cnt[i] + CNT_W'(1);
                    fin <= fin | bus.ch_done;
                    to_flag <= to_flag | ({N_CH{hit}} & ~(fin | bus.ch_done));
                    if (all_fin || hit) state <= ACCUM;
                end
                ACCUM: begin
                    for (int i = 0; i < N_CH; i++) total[i] <= sum[i][CNT_W] ? '1 : sum[i][CNT_W-1:0];
                    run_cnt <= run_cnt + RUNS_W'(1);
                    state <= last_run ? DECIDE : LAUNCH;
                end
                DECIDE: begin
                    state <= IDLE;
                    bus.done <= 1'b1;
                    bus.winner_onehot <= w_found ? N_CH'(1) << w_idx : '0;
                    bus.winner_idx <= w_idx;
                    bus.timeout_any <= |to_flag;
                    if (!bus.soft_clear) bus.done_latched <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bench_race_ctrl.sv
// tb_bench_race_ctrl: randomized benchmarks against a run-level timeline model, plus directed
// scenarios with literal expectations.
module tb_bench_race_ctrl;
    localparam int N = 4;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bench_race_ctrl_if #(.N_CH(N), .RUNS_W(8)) bi ();
    bench_race_ctrl #(.N_CH(N), .CNT_W(8), .TIMEOUT(TO), .RUNS_W(8)) dut (.clk(clk), .rst(rst), .bus(bi.slave));

    int m_cnt[N], m_tot[N], m_runs;
    bit m_to[N];
    bit e_busy, e_chs, e_done, e_dl, e_toa, e_rv, chk_en, lvl;
    logic [N-1:0] e_oh;
    logic [1:0] e_idx;
    logic [31:0] e_rd;
    int n_cmp = 0, n_err = 0, n_done = 0, cyc = 0, last_done = 0, start_cyc = 0;
    int dly[16][N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("busy", 32'(bi.busy), 32'(e_busy));
        chk("ch_start", 32'(bi.ch_start), 32'({N{e_chs}}));
        chk("done", 32'(bi.done), 32'(e_done));
        chk("done_latched", 32'(bi.done_latched), 32'(e_dl));
        chk("winner_onehot", 32'(bi.winner_onehot), 32'(e_oh));
        chk("winner_idx", 32'(bi.winner_idx), 32'(e_idx));
        chk("timeout_any", 32'(bi.timeout_any), 32'(e_toa));
        chk("rd_valid", 32'(bi.rd_valid), 32'(e_rv));
        chk("rd_data", bi.rd_data, e_rd);
        if (bi.done === 1'b1) begin
            n_done++;
            last_done = cyc;
        end
    end

    function automatic logic [31:0] mread(input logic [5:0] a);
        int ai = int'(a);
        if (ai == 0) return {29'b0, e_toa, e_dl, e_busy};
        if (ai == 1) return {20'b0, 2'b0, e_idx, 4'b0, e_oh};
        if (ai == 2) return 32'(m_runs);
        if (ai >= 16 && ai < 16 + N) return 32'(m_cnt[ai-16]);
        if (ai >= 32 && ai < 32 + N) return 32'(m_tot[ai-32]);
        return 32'h0;
    endfunction

    // Advances one cycle; a read requested this cycle shows up in the next.
    task automatic step();
        bit p;
        logic [31:0] v;
        p = bi.rd_en;
        v = mread(bi.rd_addr);
        @(posedge clk);
        #1;
        e_rv = p && !rst;
        if (p && !rst) e_rd = v;
    endtask

    task automatic rd(input logic [5:0] a);
        bi.rd_en = 1'b1;
        bi.rd_addr = a;
        step();
        bi.rd_en = 1'b0;
        step();
    endtask

    task automatic run_bench(input int nr, input bit abf, input bit sc);
        int nre, len, ab, best;
        int c[N];
        bit t[N];
        nre = (nr == 0) ? 1 : nr;
        start_cyc = cyc;
        bi.start = 1'b1;
        bi.runs = 8'(nr);
        lvl = 1'($urandom_range(0, 1));
        step();
        bi.start = 1'b0;
        e_busy = 1'b1;
        e_dl = 1'b0;
        m_runs = 0;
        for (int i = 0; i < N; i++) begin
            m_tot[i] = 0;
            m_to[i] = 1'b0;
        end
        for (int r = 0; r < nre; r++) begin
            e_chs = 1'b1;
            bi.ch_done = 4'($urandom);
            len = 0;
            for (int i = 0; i < N; i++) begin
                t[i] = dly[r][i] == 0 || dly[r][i] > TO;
                c[i] = t[i] ? TO : dly[r][i];
                if (c[i] > len) len = c[i];
            end
            ab = (abf && r == 0) ? int'($urandom_range(1, len)) : 0;
            step();
            e_chs = 1'b0;
            for (int k = 1; k <= len; k++) begin
                for (int i = 0; i < N; i++)
                    bi.ch_done[i] = dly[r][i] != 0 && (lvl ? k >= dly[r][i] : k == dly[r][i]);
                if (k == ab) begin
                    bi.abort = 1'b1;
                    bi.start = 1'b1;
                    step();
                    bi.abort = 1'b0;
                    bi.start = 1'b0;
                    bi.ch_done = '0;
                    e_busy = 1'b0;
                    for (int i = 0; i < N; i++)
                        m_cnt[i] = (dly[r][i] != 0 && dly[r][i] < k) ? dly[r][i] : k - 1;
                    return;
                end
                step();
            end
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = c[i];
                m_to[i] = m_to[i] | t[i];
            end
            bi.ch_done = 4'($urandom);
            step();
            for (int i = 0; i < N; i++)
                m_tot[i] = (m_tot[i] + m_cnt[i] > 255) ? 255 : m_tot[i] + m_cnt[i];
            m_runs++;
        end
        bi.ch_done = '0;
        bi.soft_clear = sc;
        step();
        bi.soft_clear = 1'b0;
        best = -1;
        e_toa = 1'b0;
        for (int i = 0; i < N; i++) begin
            e_toa = e_toa | m_to[i];
            if (!m_to[i] && (best < 0 || m_tot[i] < m_tot[best])) best = i;
        end
        e_busy = 1'b0;
        e_done = 1'b1;
        e_dl = !sc;
        e_oh = (best < 0) ? '0 : 4'(1 << best);
        e_idx = (best < 0) ? 2'd0 : 2'(best);
        step();
        e_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0, nr;
        bit sc;
        rst = 1'b1;
        bi.start = 1'b0;
        bi.abort = 1'b0;
        bi.soft_clear = 1'b0;
        bi.runs = '0;
        bi.ch_done = '0;
        bi.rd_en = 1'b0;
        bi.rd_addr = '0;
        {e_busy, e_chs, e_done, e_dl, e_toa, e_rv, chk_en} = '0;
        e_oh = '0;
        e_idx = '0;
        e_rd = '0;
        m_runs = 0;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_tot[i] = 0;
            m_to[i] = 1'b0;
        end
        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        step();
        rd(6'h13);
        chk("rd13_after_reset", bi.rd_data, 32'h0);

        dly[0] = '{3, 5, 2, 9};
        d0 = n_done;
        run_bench(1, 1'b0, 1'b0);
        chk("r39_done_count", 32'(n_done - d0), 32'd1);
        chk("r39_onehot", 32'(bi.winner_onehot), 32'h4);
        chk("r39_idx", 32'(bi.winner_idx), 32'd2);
        rd(6'h13);
        chk("r39_cnt3", bi.rd_data, 32'd9);
        rd(6'h12);
        chk("r39_cnt2", bi.rd_data, 32'd2);

        dly[0] = '{4, 5, 4, 7};
        dly[1] = '{4, 5, 4, 7};
        dly[2] = '{4, 5, 6, 7};
        run_bench(3, 1'b0, 1'b0);
        chk("r40_model_tot2", 32'(m_tot[2]), 32'd14);
        chk("r40_idx", 32'(bi.winner_idx), 32'd0);
        rd(6'h21);
        chk("r40_tot1", bi.rd_data, 32'd15);
        rd(6'h23);
        chk("r40_tot3", bi.rd_data, 32'd21);
        rd(6'h02);
        chk("r40_runs", bi.rd_data, 32'd3);

        dly[0] = '{0, 0, 0, 0};
        run_bench(1, 1'b0, 1'b0);
        chk("r42_onehot", 32'(bi.winner_onehot), 32'h0);
        chk("r42_timeout_any", 32'(bi.timeout_any), 32'd1);
        chk("r42_done_cycle", 32'(last_done - start_cyc), 32'd24);

        dly[0] = '{10, 0, 10, 10};
        run_bench(1, 1'b0, 1'b0);
        chk("r41_idx", 32'(bi.winner_idx), 32'd0);
        chk("r41_onehot", 32'(bi.winner_onehot), 32'h1);
        chk("r41_timeout_any", 32'(bi.timeout_any), 32'd1);
        rd(6'h11);
        chk("r41_cnt1", bi.rd_data, 32'd20);

        // Abort in MEASURE cycle 3 with a simultaneous start.
        dly[0] = '{5, 1, 6, 7};
        d0 = n_done;
        bi.start = 1'b1;
        bi.runs = 8'd1;
        step();
        bi.start = 1'b0;
        e_busy = 1'b1;
        e_chs = 1'b1;
        e_dl = 1'b0;
        m_runs = 0;
        for (int i = 0; i < N; i++) begin
            m_tot[i] = 0;
            m_to[i] = 1'b0;
        end
        step();
        e_chs = 1'b0;
        bi.ch_done = 4'b0010;
        step();
        bi.ch_done = '0;
        step();
        bi.abort = 1'b1;
        bi.start = 1'b1;
        step();
        bi.abort = 1'b0;
        bi.start = 1'b0;
        e_busy = 1'b0;
        m_cnt = '{2, 1, 2, 2};
        step();
        chk("r43_no_done", 32'(n_done - d0), 32'd0);
        chk("r43_busy", 32'(bi.busy), 32'd0);
        chk("r43_onehot_kept", 32'(bi.winner_onehot), 32'h1);
        rd(6'h10);
        chk("r43_cnt0_frozen", bi.rd_data, 32'd2);
        rd(6'h11);
        chk("r43_cnt1_frozen", bi.rd_data, 32'd1);

        for (int r = 0; r < 15; r++) dly[r] = '{18, 0, 17, 19};
        run_bench(15, 1'b0, 1'b0);
        rd(6'h20);
        chk("sat_tot0", bi.rd_data, 32'd255);
        rd(6'h22);
        chk("sat_tot2", bi.rd_data, 32'd255);
        chk("sat_idx", 32'(bi.winner_idx), 32'd0);

        dly[0] = '{1, 2, 3, 4};
        run_bench(1, 1'b0, 1'b1);
        chk("r44_soft_clear_wins", 32'(bi.done_latched), 32'd0);
        rd(6'h14);
        chk("unmapped_14", bi.rd_data, 32'h0);
        rd(6'h3F);
        chk("unmapped_3f", bi.rd_data, 32'h0);

        // Reset in the middle of a benchmark.
        d0 = n_done;
        bi.start = 1'b1;
        bi.runs = 8'd2;
        step();
        bi.start = 1'b0;
        e_busy = 1'b1;
        e_chs = 1'b1;
        e_dl = 1'b0;
        step();
        e_chs = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        {e_busy, e_chs, e_done, e_dl, e_toa, e_rv} = '0;
        e_oh = '0;
        e_idx = '0;
        e_rd = '0;
        m_runs = 0;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_tot[i] = 0;
            m_to[i] = 1'b0;
        end
        step();
        chk("rst_mid_no_done", 32'(n_done - d0), 32'd0);

        for (int n = 0; n < 30; n++) begin
            nr = int'($urandom_range(0, 4));
            for (int r = 0; r < ((nr == 0) ? 1 : nr); r++)
                for (int i = 0; i < N; i++)
                    dly[r][i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24));
            run_bench(nr, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
            for (int j = 0; j < 3; j++) rd(6'($urandom_range(0, 3) * 16 + $urandom_range(0, 5)));
            sc = $urandom_range(0, 3) == 0;
            bi.soft_clear = sc;
            step();
            bi.soft_clear = 1'b0;
            if (sc) e_dl = 1'b0;
        end
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
